// File: rtl/pc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// pc_seq_ctrl
//   Program-counter sequencing controller for the CPU core. Owns every PC
//   update: it selects the PC input mux source, strobes the PC write enable
//   and runs the instruction-fetch read handshake for the reset vector, the
//   opcode word, the extension words and the interrupt vector.
//
// Parameters
//   RESET_VEC  address of the reset vector word
//   IRQ_VEC    address of the maskable interrupt vector word
//   VEC_SHIFT  1: vector word is a word index, PC <- MDB<<1 (sel 1); 0: PC <- MDB (sel 0)
//   TIMEOUT    wait cycles without mem_rdy before a bus error (1..15)
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   mem_rdy        MDB valid for the outstanding read
//   dec_valid      decoder result valid; ext_words (0..2, 3 -> 2) sampled with it
//   exec_done      execute unit finished; pc_from_calc requests PC <- CALC_OUT
//   irq_req        masked level interrupt request, sampled at exec completion
//   pc_sel, pc_we  PC mux select (0 MDB,1 MDB<<1,2 CALC,3 hold,4 PC+2) / write enable
//   mem_rd         read request, held until mem_rdy
//   mab_vec_en     MAB from mab_vec (1) or PC (0); mab_vec = vector address
//   ir_load        load IR from MDB; ext_load = load extension register from MDB
//   irq_ack        pulse when the IRQ vector is written into PC
//   bus_err        pulse on mem_rdy timeout (controller restarts at reset vector)
// -----------------------------------------------------------------------------
module pc_seq_ctrl #(
   parameter logic [15:0] RESET_VEC = 16'hFFFE,
   parameter logic [15:0] IRQ_VEC   = 16'hFFF0,
   parameter int          VEC_SHIFT = 0,
   parameter logic [3:0]  TIMEOUT   = 4'd15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_rdy,
   input  logic        dec_valid,
   input  logic [1:0]  ext_words,
   input  logic        exec_done,
   input  logic        pc_from_calc,
   input  logic        irq_req,
   output logic [2:0]  pc_sel,
   output logic        pc_we,
   output logic        mem_rd,
   output logic        mab_vec_en,
   output logic [15:0] mab_vec,
   output logic        ir_load,
   output logic        ext_load,
   output logic        irq_ack,
   output logic        bus_err
);

   typedef enum logic [2:0] {
      ST_RST_VEC = 3'd0,
      ST_FETCH   = 3'd1,
      ST_DECODE  = 3'd2,
      ST_EXT     = 3'd3,
      ST_EXEC    = 3'd4,
      ST_IRQ_VEC = 3'd5
   } state_t;

   localparam logic [2:0] SEL_MDB  = 3'd0;
   localparam logic [2:0] SEL_MDB1 = 3'd1;
   localparam logic [2:0] SEL_CALC = 3'd2;
   localparam logic [2:0] SEL_HOLD = 3'd3;
   localparam logic [2:0] SEL_INC2 = 3'd4;
   localparam logic [2:0] SEL_VEC  = (VEC_SHIFT != 0) ? SEL_MDB1 : SEL_MDB;

   state_t      state_q, state_d;
   // init_q covers the cycle following a reset edge: outputs stay at their
   // idle values until an edge samples rst low, then RST_VEC starts its read.
   logic        init_q, init_d;
   logic [3:0]  wait_q, wait_d;
   logic [1:0]  ext_cnt_q, ext_cnt_d;
   // gap_q forces one idle cycle of mem_rd between consecutive extension words
   logic        gap_q, gap_d;

   // Next-state, handshake counters and combinational outputs
   always_comb begin
      state_d    = state_q;
      init_d     = 1'b0;
      ext_cnt_d  = ext_cnt_q;
      gap_d      = gap_q;
      wait_d     = 4'd0;
      pc_sel     = SEL_HOLD;
      pc_we      = 1'b0;
      mem_rd     = 1'b0;
      mab_vec_en = 1'b0;
      mab_vec    = RESET_VEC;
      ir_load    = 1'b0;
      ext_load   = 1'b0;
      irq_ack    = 1'b0;
      bus_err    = 1'b0;

      if (init_q) begin
         state_d   = ST_RST_VEC;
         ext_cnt_d = 2'd0;
         gap_d     = 1'b0;
      end else begin
         case (state_q)
            ST_RST_VEC: begin
               mem_rd     = 1'b1;
               mab_vec_en = 1'b1;
               mab_vec    = RESET_VEC;
               if (mem_rdy) begin
                  pc_sel  = SEL_VEC;
                  pc_we   = 1'b1;
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_RST_VEC;
               end
            end
            ST_FETCH: begin
               mem_rd = 1'b1;
               if (mem_rdy) begin
                  ir_load = 1'b1;
                  pc_sel  = SEL_INC2;
                  pc_we   = 1'b1;
                  state_d = ST_DECODE;
               end else begin
                  state_d = ST_FETCH;
               end
            end
            ST_DECODE: begin
               gap_d = 1'b0;
               if (dec_valid) begin
                  case (ext_words)
                     2'd0: begin
                        ext_cnt_d = 2'd0;
                        state_d   = ST_EXEC;
                     end
                     2'd1: begin
                        ext_cnt_d = 2'd1;
                        state_d   = ST_EXT;
                     end
                     default: begin
                        // 2 and the illegal 3 both fetch two words
                        ext_cnt_d = 2'd2;
                        state_d   = ST_EXT;
                     end
                  endcase
               end else begin
                  state_d = ST_DECODE;
               end
            end
            ST_EXT: begin
               if (gap_q) begin
                  gap_d = 1'b0;
               end else begin
                  mem_rd = 1'b1;
                  if (mem_rdy) begin
                     ext_load  = 1'b1;
                     pc_sel    = SEL_INC2;
                     pc_we     = 1'b1;
                     ext_cnt_d = ext_cnt_q - 2'd1;
                     if (ext_cnt_q <= 2'd1) begin
                        state_d = ST_EXEC;
                        gap_d   = 1'b0;
                     end else begin
                        gap_d = 1'b1;
                     end
                  end else begin
                     gap_d = 1'b0;
                  end
               end
            end
            ST_EXEC: begin
               if (exec_done) begin
                  if (pc_from_calc) begin
                     pc_sel = SEL_CALC;
                     pc_we  = 1'b1;
                  end else begin
                     pc_sel = SEL_HOLD;
                  end
                  state_d = irq_req ? ST_IRQ_VEC : ST_FETCH;
               end else begin
                  state_d = ST_EXEC;
               end
            end
            ST_IRQ_VEC: begin
               mem_rd     = 1'b1;
               mab_vec_en = 1'b1;
               mab_vec    = IRQ_VEC;
               if (mem_rdy) begin
                  pc_sel  = SEL_VEC;
                  pc_we   = 1'b1;
                  irq_ack = 1'b1;
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_IRQ_VEC;
               end
            end
            default: begin
               state_d = ST_RST_VEC;
            end
         endcase

         // Timeout: the wait count is the number of earlier unanswered
         // request cycles, so the TIMEOUT-th unanswered cycle raises bus_err.
         if (mem_rd && !mem_rdy) begin
            if (wait_q == (TIMEOUT - 4'd1)) begin
               bus_err   = 1'b1;
               state_d   = ST_RST_VEC;
               ext_cnt_d = 2'd0;
               gap_d     = 1'b0;
               wait_d    = 4'd0;
            end else begin
               wait_d = wait_q + 4'd1;
            end
         end else begin
            wait_d = 4'd0;
         end
      end
   end

   // State and counter registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_RST_VEC;
         init_q    <= 1'b1;
         wait_q    <= 4'd0;
         ext_cnt_q <= 2'd0;
         gap_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         init_q    <= init_d;
         wait_q    <= wait_d;
         ext_cnt_q <= ext_cnt_d;
         gap_q     <= gap_d;
      end
   end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_seq_ctrl
//   Directed bench for pc_seq_ctrl. Two instances share the stimulus: u0 with
//   VEC_SHIFT=0 sees MDB, u1 with VEC_SHIFT=1 sees MDB>>1, so both must end up
//   with the same PC. A bench-side PC register per instance follows pc_sel /
//   pc_we; every expected PC write is queued when stimulus is driven and
//   popped when the controller raises pc_we.
// -----------------------------------------------------------------------------
module tb_pc_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_rdy = 1'b0;
   logic        dec_valid = 1'b0;
   logic [1:0]  ext_words = 2'd0;
   logic        exec_done = 1'b0;
   logic        pc_from_calc = 1'b0;
   logic        irq_req = 1'b0;
   logic [15:0] mdb = 16'h0000;
   logic [15:0] mdb1;
   logic [15:0] calc_out = 16'h0000;

   logic [2:0]  pc_sel0, pc_sel1;
   logic        pc_we0, pc_we1, mem_rd0, mem_rd1, mab_vec_en0, mab_vec_en1;
   logic [15:0] mab_vec0, mab_vec1;
   logic        ir_load0, ir_load1, ext_load0, ext_load1;
   logic        irq_ack0, irq_ack1, bus_err0, bus_err1;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [2:0]  sel;
      logic        vec;
      logic [15:0] pc;
   } exp_t;

   exp_t sb[$];

   logic [15:0] pc0 = 16'h0000;
   logic [15:0] pc1 = 16'h0000;
   logic [15:0] nxt0, nxt1;

   assign mdb1 = mdb >> 1;

   always #5 clk = ~clk;

   pc_seq_ctrl #(.RESET_VEC(16'hFFFE), .IRQ_VEC(16'hFFF0), .VEC_SHIFT(0), .TIMEOUT(4'd15)) u0 (
      .clk(clk), .rst(rst), .mem_rdy(mem_rdy), .dec_valid(dec_valid), .ext_words(ext_words),
      .exec_done(exec_done), .pc_from_calc(pc_from_calc), .irq_req(irq_req),
      .pc_sel(pc_sel0), .pc_we(pc_we0), .mem_rd(mem_rd0), .mab_vec_en(mab_vec_en0),
      .mab_vec(mab_vec0), .ir_load(ir_load0), .ext_load(ext_load0), .irq_ack(irq_ack0),
      .bus_err(bus_err0));

   pc_seq_ctrl #(.RESET_VEC(16'hFFFE), .IRQ_VEC(16'hFFF0), .VEC_SHIFT(1), .TIMEOUT(4'd15)) u1 (
      .clk(clk), .rst(rst), .mem_rdy(mem_rdy), .dec_valid(dec_valid), .ext_words(ext_words),
      .exec_done(exec_done), .pc_from_calc(pc_from_calc), .irq_req(irq_req),
      .pc_sel(pc_sel1), .pc_we(pc_we1), .mem_rd(mem_rd1), .mab_vec_en(mab_vec_en1),
      .mab_vec(mab_vec1), .ir_load(ir_load1), .ext_load(ext_load1), .irq_ack(irq_ack1),
      .bus_err(bus_err1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] pc_mux(input logic [2:0] sel, input logic [15:0] d,
                                          input logic [15:0] c, input logic [15:0] pc);
      case (sel)
         3'd0:    return d;
         3'd1:    return d << 1;
         3'd2:    return c;
         3'd4:    return pc + 16'd2;
         default: return pc;
      endcase
   endfunction

   task automatic push(input logic [2:0] sel, input logic vec, input logic [15:0] pc);
      exp_t e;
      e.sel = sel;
      e.vec = vec;
      e.pc  = pc;
      sb.push_back(e);
   endtask

   task automatic to_next();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_pc_sel"},     {29'd0, pc_sel0},     32'd3);
      chk({tag, "_pc_we"},      {31'd0, pc_we0},      32'd0);
      chk({tag, "_mem_rd"},     {31'd0, mem_rd0},     32'd0);
      chk({tag, "_mab_vec_en"}, {31'd0, mab_vec_en0}, 32'd0);
      chk({tag, "_mab_vec"},    {16'd0, mab_vec0},    32'h0000FFFE);
      chk({tag, "_ir_load"},    {31'd0, ir_load0},    32'd0);
      chk({tag, "_ext_load"},   {31'd0, ext_load0},   32'd0);
      chk({tag, "_irq_ack"},    {31'd0, irq_ack0},    32'd0);
      chk({tag, "_bus_err"},    {31'd0, bus_err0},    32'd0);
   endtask

   // Scoreboard side: every PC write must match the next queued expectation
   always @(negedge clk) begin
      nxt0 = pc_mux(pc_sel0, mdb,  calc_out, pc0);
      nxt1 = pc_mux(pc_sel1, mdb1, calc_out, pc1);
      if (pc_we0 === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_pc_we", {31'd0, pc_we0}, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("pc_sel_u0", {29'd0, pc_sel0}, {29'd0, (e.vec ? 3'd0 : e.sel)});
            chk("pc_sel_u1", {29'd0, pc_sel1}, {29'd0, (e.vec ? 3'd1 : e.sel)});
            chk("pc_we_u1",  {31'd0, pc_we1},  32'd1);
            chk("pc_next_u0", {16'd0, nxt0}, {16'd0, e.pc});
            chk("pc_next_u1", {16'd0, nxt1}, {16'd0, e.pc});
         end
      end
   end

   // Bench-side PC registers standing in for the datapath
   always @(posedge clk) begin
      if (pc_we0 === 1'b1) pc0 <= nxt0;
      if (pc_we1 === 1'b1) pc1 <= nxt1;
   end

   initial begin
      // ---------------- reset, vector fetch with one wait cycle ----------------
      to_next();
      @(negedge clk); chk_reset_outs("rst1");
      to_next();
      rst = 1'b0;
      @(negedge clk); chk_reset_outs("rst2");
      to_next();
      @(negedge clk);
      chk("rv_mem_rd",     {31'd0, mem_rd0},     32'd1);
      chk("rv_mab_vec_en", {31'd0, mab_vec_en0}, 32'd1);
      chk("rv_mab_vec",    {16'd0, mab_vec0},    32'h0000FFFE);
      chk("rv_wait_no_we", {31'd0, pc_we0},      32'd0);
      to_next();
      mem_rdy = 1'b1; mdb = 16'hC000; push(3'd0, 1'b1, 16'hC000);
      @(negedge clk); chk("rv_rdy_mem_rd", {31'd0, mem_rd0}, 32'd1);
      to_next();

      // ---------------- instruction without extension words ----------------
      mdb = 16'h4000; push(3'd4, 1'b0, 16'hC002);
      @(negedge clk);
      chk("f1_pc",      {16'd0, pc0},         32'h0000C000);
      chk("f1_mab_pc",  {31'd0, mab_vec_en0}, 32'd0);
      chk("f1_ir_load", {31'd0, ir_load0},    32'd1);
      to_next();
      mem_rdy = 1'b0; dec_valid = 1'b1; ext_words = 2'd0;
      @(negedge clk);
      chk("d1_mem_rd",  {31'd0, mem_rd0},  32'd0);
      chk("d1_ir_load", {31'd0, ir_load0}, 32'd0);
      to_next();
      dec_valid = 1'b0; exec_done = 1'b1; pc_from_calc = 1'b0;
      @(negedge clk);
      chk("e1_pc_sel", {29'd0, pc_sel0}, 32'd3);
      chk("e1_pc_we",  {31'd0, pc_we0},  32'd0);
      to_next();

      // ---------------- two extension words + jump, IRQ raised in EXT ----------------
      exec_done = 1'b0; mem_rdy = 1'b1; mdb = 16'h4123; push(3'd4, 1'b0, 16'hC004);
      @(negedge clk);
      chk("f2_pc",      {16'd0, pc0},      32'h0000C002);
      chk("f2_ir_load", {31'd0, ir_load0}, 32'd1);
      to_next();
      mem_rdy = 1'b0; dec_valid = 1'b1; ext_words = 2'd2;
      @(negedge clk); chk("d2_mem_rd", {31'd0, mem_rd0}, 32'd0);
      to_next();
      dec_valid = 1'b0; mem_rdy = 1'b1; mdb = 16'h1111; push(3'd4, 1'b0, 16'hC006);
      @(negedge clk);
      chk("x1_mem_rd",   {31'd0, mem_rd0},   32'd1);
      chk("x1_ext_load", {31'd0, ext_load0}, 32'd1);
      to_next();
      irq_req = 1'b1;   // mem_rdy stays high but no read is pending in the gap
      @(negedge clk);
      chk("gap_mem_rd",   {31'd0, mem_rd0},   32'd0);
      chk("gap_ext_load", {31'd0, ext_load0}, 32'd0);
      to_next();
      mem_rdy = 1'b0;
      @(negedge clk);
      chk("x2_wait_mem_rd",   {31'd0, mem_rd0},   32'd1);
      chk("x2_wait_ext_load", {31'd0, ext_load0}, 32'd0);
      to_next();
      mem_rdy = 1'b1; mdb = 16'h2222; push(3'd4, 1'b0, 16'hC008);
      @(negedge clk); chk("x2_ext_load", {31'd0, ext_load0}, 32'd1);
      to_next();
      mem_rdy = 1'b0;
      @(negedge clk);
      chk("ex_idle_mem_rd", {31'd0, mem_rd0}, 32'd0);
      chk("ex_idle_pc",     {16'd0, pc0},     32'h0000C008);
      to_next();
      exec_done = 1'b1; pc_from_calc = 1'b1; calc_out = 16'hC100; push(3'd2, 1'b0, 16'hC100);
      @(negedge clk); chk("ex_jump_we", {31'd0, pc_we0}, 32'd1);
      to_next();
      exec_done = 1'b0; pc_from_calc = 1'b0;
      @(negedge clk);
      chk("iv_pc",         {16'd0, pc0},         32'h0000C100);
      chk("iv_mem_rd",     {31'd0, mem_rd0},     32'd1);
      chk("iv_mab_vec_en", {31'd0, mab_vec_en0}, 32'd1);
      chk("iv_mab_vec",    {16'd0, mab_vec0},    32'h0000FFF0);
      chk("iv_wait_ack",   {31'd0, irq_ack0},    32'd0);
      to_next();
      mem_rdy = 1'b1; mdb = 16'hD000; push(3'd0, 1'b1, 16'hD000);
      @(negedge clk);
      chk("iv_ack_u0", {31'd0, irq_ack0}, 32'd1);
      chk("iv_ack_u1", {31'd0, irq_ack1}, 32'd1);
      to_next();
      irq_req = 1'b0; mem_rdy = 1'b0;

      // ---------------- fetch timeout -> bus error -> reset vector ----------------
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk);
         if (i == 1) begin
            chk("irq_pc_u0", {16'd0, pc0},         32'h0000D000);
            chk("irq_pc_u1", {16'd0, pc1},         32'h0000D000);
            chk("ack_pulse", {31'd0, irq_ack0},    32'd0);
            chk("fetch_mab", {31'd0, mab_vec_en0}, 32'd0);
         end
         chk($sformatf("to_mem_rd_%0d", i),  {31'd0, mem_rd0},  32'd1);
         chk($sformatf("to_bus_err_%0d", i), {31'd0, bus_err0}, (i == 15) ? 32'd1 : 32'd0);
         to_next();
      end
      @(negedge clk);
      chk("be_pulse",      {31'd0, bus_err0},    32'd0);
      chk("be_mab_vec_en", {31'd0, mab_vec_en0}, 32'd1);
      chk("be_mab_vec",    {16'd0, mab_vec0},    32'h0000FFFE);
      chk("be_mem_rd",     {31'd0, mem_rd0},     32'd1);
      to_next();
      mem_rdy = 1'b1; mdb = 16'hC000; push(3'd0, 1'b1, 16'hC000);
      to_next();

      // ---------------- reset in the middle of EXT ----------------
      mdb = 16'h4000; push(3'd4, 1'b0, 16'hC002);
      to_next();
      mem_rdy = 1'b0; dec_valid = 1'b1; ext_words = 2'd3;   // treated as two words
      to_next();
      dec_valid = 1'b0; mem_rdy = 1'b1; push(3'd4, 1'b0, 16'hC004);
      to_next();
      mem_rdy = 1'b0;
      @(negedge clk); chk("mx_gap_mem_rd", {31'd0, mem_rd0}, 32'd0);
      to_next();
      rst = 1'b1;
      @(negedge clk); chk("mx_mem_rd", {31'd0, mem_rd0}, 32'd1);
      to_next();
      rst = 1'b0;
      @(negedge clk); chk_reset_outs("mid_rst");
      to_next();
      @(negedge clk);
      chk("mx_rv_mem_rd",  {31'd0, mem_rd0},     32'd1);
      chk("mx_rv_mab_en",  {31'd0, mab_vec_en0}, 32'd1);
      chk("final_pc",      {16'd0, pc0},         32'h0000C004);
      chk("sb_empty",      sb.size(),            32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard stop in case the directed sequence ever stalls
   initial begin
      #20000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
